// File: rtl/systolic_ctrl.sv
// Sequencer for an NxN broadcast systolic array: clears the array, streams one
// A column / B row per cycle for N cycles, then captures (optionally ReLU'd) C.
module systolic_ctrl #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int Accw = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  relu_en,
  input  logic [N*N*W-1:0]      a_mat,
  input  logic [N*N*W-1:0]      b_mat,
  input  logic [N*N*Accw-1:0]   acc_in,
  output logic                  arr_clr,
  output logic                  systolic_en,
  output logic [N*W-1:0]        a_in,
  output logic [N*W-1:0]        b_in,
  output logic [N*N*Accw-1:0]   result,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            o_dbg_state
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_COMPUTE = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                r_state;
  logic [KW-1:0]         r_k;
  logic [N*N*W-1:0]      r_a_lat;
  logic [N*N*W-1:0]      r_b_lat;
  logic                  r_relu;
  logic                  r_arr_clr;
  logic                  r_systolic_en;
  logic [N*W-1:0]        r_a_in;
  logic [N*W-1:0]        r_b_in;
  logic [N*N*Accw-1:0]   r_result;
  logic                  r_busy;
  logic                  r_done;

  logic [KW-1:0]         w_k_sel;
  logic [N*W-1:0]        w_a_col;
  logic [N*W-1:0]        w_b_row;
  logic [N*N*Accw-1:0]   w_capture;
  logic [Accw-1:0]       w_pe_val;

  // Operand column/row for the k that will be on the bus next cycle.
  always_comb begin
    w_k_sel = '0;
    if (r_state == S_COMPUTE && r_k != KW'(N - 1))
      w_k_sel = r_k + KW'(1);
    w_a_col = '0;
    w_b_row = '0;
    for (int i = 0; i < N; i++) begin
      w_a_col[i*W +: W] = r_a_lat[(i*N + int'(w_k_sel))*W +: W];
      w_b_row[i*W +: W] = r_b_lat[(int'(w_k_sel)*N + i)*W +: W];
    end
  end

  // The array reports PE(i,j) at the mirrored slot; un-mirror while capturing.
  always_comb begin
    w_capture = '0;
    w_pe_val  = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        w_pe_val = acc_in[((N-1-r)*N + (N-1-c))*Accw +: Accw];
        if (r_relu && w_pe_val[Accw-1])
          w_pe_val = '0;
        w_capture[(r*N + c)*Accw +: Accw] = w_pe_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_k           <= '0;
      r_a_lat       <= '0;
      r_b_lat       <= '0;
      r_relu        <= 1'b0;
      r_arr_clr     <= 1'b0;
      r_systolic_en <= 1'b0;
      r_a_in        <= '0;
      r_b_in        <= '0;
      r_result      <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_lat   <= a_mat;
            r_b_lat   <= b_mat;
            r_relu    <= relu_en;
            r_arr_clr <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_arr_clr     <= 1'b0;
          r_systolic_en <= 1'b1;
          r_k           <= '0;
          r_a_in        <= w_a_col;
          r_b_in        <= w_b_row;
          r_state       <= S_COMPUTE;
        end
        S_COMPUTE: begin
          if (r_k == KW'(N - 1)) begin
            r_systolic_en <= 1'b0;
            r_a_in        <= '0;
            r_b_in        <= '0;
            r_k           <= '0;
            r_state       <= S_CAPTURE;
          end else begin
            r_k    <= w_k_sel;
            r_a_in <= w_a_col;
            r_b_in <= w_b_row;
          end
        end
        S_CAPTURE: begin
          r_result <= w_capture;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign arr_clr     = r_arr_clr;
  assign systolic_en = r_systolic_en;
  assign a_in        = r_a_in;
  assign b_in        = r_b_in;
  assign result      = r_result;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: a behavioural broadcast array closes the loop and
// every product is compared against a plain-arithmetic matrix multiply.
module tb_systolic_ctrl;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int Accw = 32;

  // Handshake: start is a level request sampled only while the controller is
  // idle; done is a single-cycle pulse marking result as freshly updated.
  logic                 clk;
  logic                 rst;
  logic                 start;
  logic                 relu_en;
  logic [N*N*W-1:0]     a_mat;
  logic [N*N*W-1:0]     b_mat;
  logic [N*N*Accw-1:0]  acc_in;
  logic                 arr_clr;
  logic                 systolic_en;
  logic [N*W-1:0]       a_in;
  logic [N*W-1:0]       b_in;
  logic [N*N*Accw-1:0]  result;
  logic                 busy;
  logic                 done;
  logic [2:0]           dbg_state;

  int checks = 0;
  int errors = 0;
  logic [Accw-1:0] exp_q[$];

  systolic_ctrl #(.N(N), .W(W), .Accw(Accw)) dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
    .a_mat(a_mat), .b_mat(b_mat), .acc_in(acc_in),
    .arr_clr(arr_clr), .systolic_en(systolic_en),
    .a_in(a_in), .b_in(b_in), .result(result),
    .busy(busy), .done(done), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural array ----------------
  logic signed [Accw-1:0] pe [N][N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (arr_clr)
          pe[i][j] <= '0;
        else if (systolic_en)
          pe[i][j] <= pe[i][j] + $signed(a_in[i*W +: W]) * $signed(b_in[j*W +: W]);
  end

  always_comb begin
    acc_in = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        acc_in[((N-1-i)*N + (N-1-j))*Accw +: Accw] = pe[i][j];
  end

  // ---------------- reference model ----------------
  function automatic int el(input logic [N*N*W-1:0] m, input int r, input int c);
    logic signed [W-1:0] v;
    v = m[(r*N + c)*W +: W];
    return int'(v);
  endfunction

  function automatic logic [Accw-1:0] ref_el(input logic [N*N*W-1:0] a,
                                             input logic [N*N*W-1:0] b,
                                             input bit relu, input int r, input int c);
    longint s;
    s = 0;
    for (int k = 0; k < N; k++) s += longint'(el(a, r, k)) * longint'(el(b, k, c));
    if (relu && s < 0) s = 0;
    return Accw'(s);
  endfunction

  // kind: 0 identity, 1 r*N+c, 2 all -128, 3 diag -1 else 5, other random
  function automatic logic [N*N*W-1:0] build(input int kind);
    logic [N*N*W-1:0] m;
    int v;
    m = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        case (kind)
          0:       v = (r == c) ? 1 : 0;
          1:       v = r*N + c;
          2:       v = -128;
          3:       v = (r == c) ? -1 : 5;
          default: v = int'($urandom_range(0, 255)) - 128;
        endcase
        m[(r*N + c)*W +: W] = W'(v);
      end
    return m;
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".arr_clr"}, 64'(arr_clr), 64'd0);
    chk({tag, ".systolic_en"}, 64'(systolic_en), 64'd0);
    chk({tag, ".a_in"}, 64'(a_in), 64'd0);
    chk({tag, ".b_in"}, 64'(b_in), 64'd0);
    chk({tag, ".result_or"}, 64'(|result), 64'd0);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd0);
  endtask

  // ---------------- driver ----------------
  // One full operation: protocol checked every cycle, then the product.
  task automatic do_op(input string name, input logic [N*N*W-1:0] a,
                       input logic [N*N*W-1:0] b, input bit relu,
                       input bit hold, input bit scramble);
    logic [N*W-1:0] ea;
    logic [N*W-1:0] eb;
    bit en;
    @(negedge clk);
    a_mat   = a;
    b_mat   = b;
    relu_en = relu;
    start   = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int cyc = 0; cyc <= N + 3; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk);
        #1;
      end
      en = (cyc >= 1 && cyc <= N);
      ea = '0;
      eb = '0;
      if (en)
        for (int i = 0; i < N; i++) begin
          ea[i*W +: W] = W'(el(a, i, cyc - 1));
          eb[i*W +: W] = W'(el(b, cyc - 1, i));
        end
      chk($sformatf("%s.arr_clr@%0d", name, cyc), 64'(arr_clr), 64'(cyc == 0));
      chk($sformatf("%s.systolic_en@%0d", name, cyc), 64'(systolic_en), 64'(en));
      chk($sformatf("%s.a_in@%0d", name, cyc), 64'(a_in), 64'(ea));
      chk($sformatf("%s.b_in@%0d", name, cyc), 64'(b_in), 64'(eb));
      chk($sformatf("%s.busy@%0d", name, cyc), 64'(busy), 64'(cyc <= N + 1));
      chk($sformatf("%s.done@%0d", name, cyc), 64'(done), 64'(cyc == N + 2));
      if (scramble && cyc == 2) begin
        a_mat   = {$urandom, $urandom, $urandom, $urandom};
        b_mat   = {$urandom, $urandom, $urandom, $urandom};
        relu_en = ~relu;
      end
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        exp_q.push_back(ref_el(a, b, relu, r, c));
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        chk($sformatf("%s.C[%0d][%0d]", name, r, c),
            64'(result[(r*N + c)*Accw +: Accw]), 64'(exp_q.pop_front()));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N*N*W-1:0] ra;
    logic [N*N*W-1:0] rb;
    int done_seen;

    rst     = 1'b1;
    start   = 1'b0;
    relu_en = 1'b0;
    a_mat   = '0;
    b_mat   = '0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op("ident_b", build(0), build(1), 1'b0, 1'b0, 1'b0);
    chk("ident_b.C11_is_5", 64'(result[(1*N + 1)*Accw +: Accw]), 64'd5);

    do_op("neg128", build(2), build(2), 1'b0, 1'b0, 1'b0);
    chk("neg128.C00", 64'(result[Accw-1:0]), 64'd65536);

    do_op("relu_on", build(0), build(3), 1'b1, 1'b0, 1'b0);
    chk("relu_on.C22", 64'(result[(2*N + 2)*Accw +: Accw]), 64'd0);
    do_op("relu_off", build(0), build(3), 1'b0, 1'b0, 1'b0);
    chk("relu_off.C22", 64'(result[(2*N + 2)*Accw +: Accw]), 64'(32'hFFFF_FFFF));

    // start held high: back-to-back ops, inputs disturbed mid-op
    do_op("held0", build(9), build(9), 1'b1, 1'b1, 1'b1);
    do_op("held1", build(9), build(9), 1'b0, 1'b1, 1'b1);
    do_op("held2", build(9), build(9), 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (N + 4) @(negedge clk);

    // reset during COMPUTE with k=2
    @(negedge clk);
    a_mat   = build(9);
    b_mat   = build(9);
    relu_en = 1'b0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort.pre_en", 64'(systolic_en), 64'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    chk("abort.no_done", 64'(done_seen), 64'd0);
    chk("abort.idle_busy", 64'(busy), 64'd0);
    do_op("after_abort", build(9), build(9), 1'b0, 1'b0, 1'b0);

    // successive ops with different A share B
    rb = build(9);
    do_op("seq_a1", build(9), rb, 1'b0, 1'b0, 1'b0);
    do_op("seq_a2", build(9), rb, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      ra = build(9);
      rb = build(9);
      do_op($sformatf("rand%0d", t), ra, rb, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, array dimension (NxN).
REQ-002 SHALL have parameter W, default 8, signed operand width.
REQ-003 SHALL have parameter Accw, default 32, signed accumulator/result width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request one matrix multiply; accepted only in IDLE.
REQ-007 relu_en  input  1  apply ReLU to results; sampled with start.
REQ-008 a_mat  input  N*N*W  matrix A; element (r,c) at [(r*N+c)*W +: W].
REQ-009 b_mat  input  N*N*W  matrix B; same packing as a_mat.
REQ-010 acc_in  input  N*N*Accw  array acc_out; PE(i,j) sits at slot ((N-1-i)*N+(N-1-j)).
REQ-011 arr_clr  output  1  synchronous clear to array rst.
REQ-012 systolic_en  output  1  array accumulate enable.
REQ-013 a_in  output  N*W  row operands; slot i at [i*W +: W].
REQ-014 b_in  output  N*W  column operands; slot j at [j*W +: W].
REQ-015 result  output  N*N*Accw  C=A*B; element (r,c) at [(r*N+c)*Accw +: Accw].
REQ-016 busy  output  1  high in CLEAR, COMPUTE and CAPTURE.
REQ-017 done  output  1  one-cycle pulse when result updates.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR, COMPUTE, CAPTURE, DONE.
REQ-019 IDLE with start=1 -> CLEAR at that edge; a_mat, b_mat and relu_en latched at the same edge.
REQ-020 start outside IDLE SHALL be ignored; latched operands stay unchanged.
REQ-021 CLEAR: lasts 1 cycle; arr_clr=1, systolic_en=0; next state COMPUTE with k=0.
REQ-022 COMPUTE: lasts N cycles, k=0..N-1; systolic_en=1, arr_clr=0.
REQ-023 COMPUTE operand drive: a_in slot i = A[i][k]; b_in slot j = B[k][j].
REQ-024 Operands are broadcast, not skewed: the array forwards them combinationally along rows and columns.
REQ-025 Outside COMPUTE: a_in=0, b_in=0, systolic_en=0.
REQ-026 After k=N-1 -> CAPTURE (1 cycle); at CAPTURE exit edge, result(r,c) SHALL load acc_in slot ((N-1-r)*N+(N-1-c)).
REQ-027 When latched relu_en=1, captured values <0 SHALL load as 0; values >=0 pass unchanged.
REQ-028 CAPTURE -> DONE: done=1 for exactly 1 cycle, then -> IDLE unconditionally.
REQ-029 Latency: start accepted at edge E0 -> done high in the cycle after edge E(N+2); back-to-back period N+4 cycles.
REQ-030 result SHALL hold its value until the next CAPTURE.
REQ-031 No saturation: Accw SHALL be >= 2W+clog2(N); accumulation is the array's signed wrap.
REQ-032 k counter width SHALL be clog2(N), minimum 1 bit; k SHALL NOT exceed N-1.

Reset
REQ-033 rst=1 SHALL immediately force IDLE and k=0.
REQ-034 rst=1 SHALL immediately force arr_clr, systolic_en, busy and done to 0.
REQ-035 rst=1 SHALL immediately force a_in, b_in, result, latched operands and latched relu_en to 0.
REQ-036 Reset mid-operation SHALL abort it with no done; the next accepted start SHALL re-clear the array via CLEAR.

Verification (N=4, W=8, Accw=32, bench includes systolic_array_NxN)
REQ-037 A=identity, B(r,c)=r*4+c, relu_en=0 -> result equals B; done exactly 6 cycles after the start edge.
REQ-038 All A=-128, all B=-128 -> every result element = 65536.
REQ-039 A=identity, B(r,c)=-1 when r=c else 5, relu_en=1 -> diagonal 0, off-diagonal 5; same with relu_en=0 -> diagonal -1.
REQ-040 start held high continuously -> one op per 8 cycles; busy=1 and a_mat changes during an op do not alter that op's result.
REQ-041 rst pulsed during COMPUTE k=2 -> all outputs 0 that cycle, no done pulse; next start gives a correct product (no residue from the aborted op).
REQ-042 Two successive ops with different A -> second result independent of the first, proving CLEAR clears the array.
